weight_lut_reader: RTL
======================

# weight_lut_reader

Read-side controller for the 256-bit weight LUT ROM used by the layer-1 convolution. On a `start` pulse it walks the ROM addresses `BASE_ADDR, BASE_ADDR+16, …` for `NUM_WORDS` words. It absorbs the ROM's one-cycle registered read latency, buffers fetched words in a 2-entry FIFO, and serializes each word into sixteen 16-bit weights on a valid/ready stream to the MAC array.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: ROM address width.
- `DATA_WIDTH`, 256: ROM word width; must equal 16 × `WEIGHT_WIDTH`.
- `WEIGHT_WIDTH`, 16: width of one output weight.
- `NUM_WORDS`, 28: words fetched per run; must be ≥ 1.
- `ADDR_STRIDE`, 16: address increment per word.
- `BASE_ADDR`, 0: first ROM address.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `start`, in, 1: one-cycle run request; ignored while `busy`.
- `busy`, out, 1: high from the edge after `start` is accepted until the final weight handshake.
- `done`, out, 1: one-cycle pulse on the edge after the final weight handshake.
- `lut_address`, out, `ADDR_WIDTH`: registered ROM address.
- `lut_data`, in, `DATA_WIDTH`: ROM output, valid one edge after `lut_address` is sampled.
- `w_valid`, out, 1: output weight valid.
- `w_ready`, in, 1: downstream ready.
- `w_data`, out, `WEIGHT_WIDTH`: weight value.
- `w_last_word`, out, 1: high on the 16th weight of each word.
- `w_last`, out, 1: high on the final weight of the run.

## Operation
- States:
  - IDLE: `start` → FETCH; load address counter with `BASE_ADDR`; clear word counters.
  - FETCH: issue reads; when the issued count reaches `NUM_WORDS` → DRAIN.
  - DRAIN: no new reads; when the final weight handshakes → IDLE with a `done` pulse.
- Read issue rule: issue on an edge iff in FETCH, issued < `NUM_WORDS`, and fifo_count + inflight < 2. Issuing registers `lut_address` to the current address, advances the address by `ADDR_STRIDE`, and sets stage-1 of a 2-stage pending pipe.
- Pending pipe: the stage-1 flag moves to stage-2 on the next edge, when the ROM samples the address. On the edge after that, `lut_data` is written into the FIFO. inflight = stage1 + stage2.
- The FIFO never overflows because the issue rule reserves space.
- Serializer: a 256-bit shift register plus a 4-bit index. It loads from the FIFO head when empty, or when the 16th weight handshakes in the same cycle, and the FIFO is non-empty.
- `w_data` is bits [255:240] first, then [239:224], …, [15:0] last (MSB-first).
- Handshake: a transfer occurs on an edge with `w_valid && w_ready`.
  - `w_valid`, `w_data`, `w_last_word` and `w_last` hold stable while `w_valid && !w_ready`.
  - `w_valid` never drops without a transfer.
- `w_last` = `w_last_word` on word `NUM_WORDS`-1.
- `lut_address` holds its last issued value when not issuing.
- `start` is ignored while `busy`, including a `start` arriving in the same cycle as the final handshake.
- Reset (any time, including mid-run):
  - outputs: `lut_address`=0, `w_data`=0, `w_valid`=0, `w_last_word`=0, `w_last`=0, `busy`=0, `done`=0.
  - internals: FIFO count and pending pipe cleared, state IDLE.
  - A read in flight at reset is discarded.

## Timing
- `start` is sampled at edge E0.
  - `busy` and `lut_address`=`BASE_ADDR` take effect after E0.
  - The ROM samples at E1; the word is captured at E2.
  - The serializer loads at E3, so `w_valid` first rises after E3 (3-cycle start-to-first-weight latency).
- With `w_ready` held high: one weight per cycle, no bubbles between words. Each run lasts 16×`NUM_WORDS` cycles plus 3 cycles of latency.
- The final handshake at edge En makes `done`=1 and `busy`=0 after En. `done` clears after En+1.
- Under stalls, the ROM runs at most 2 words ahead of the serializer's word (FIFO full).

## Test plan
- Reset: assert `rst_n`=0 asynchronously mid-cycle → all outputs 0 immediately. Hold `start`=0 → `lut_address` stays 0, `w_valid` stays 0.
- Full run, defaults, `w_ready`=1, against the ROM model:
  - 448 weights; first `w_data`=0x0049, last `w_data`=0x0007.
  - `w_last_word` on every 16th weight; `w_last` only on weight 448.
  - Addresses 0..432 in steps of 16; `done` exactly once; first `w_valid` 3 cycles after `start`.
- Backpressure: random `w_ready` at 30% duty → the same 448 weights in order with no duplicates. Outputs stable while stalled; fifo_count + inflight never exceeds 2.
- `start` pulsed every cycle while `busy` → exactly one run; `lut_address` sequence unchanged.
- Reset mid-run after weight 100 → outputs clear. A new `start` restarts from `BASE_ADDR` with first weight 0x0049.
- `NUM_WORDS`=1, `BASE_ADDR`=432 → 16 weights, first 0xFFA2, last 0x0007. `w_last_word` and `w_last` both high on weight 16; `done` on the next edge.

Source files
------------

// File: rtl/weight_lut_reader.sv
// weight_lut_reader: fetches weight words from the LUT ROM
// and streams them out as 16-bit weights, MSB-first.
module weight_lut_reader #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 256,
  parameter int WEIGHT_WIDTH = 16,
  parameter int NUM_WORDS    = 28,
  parameter int ADDR_STRIDE  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   lut_address,
  input  logic [DATA_WIDTH-1:0]   lut_data,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [WEIGHT_WIDTH-1:0] w_data,
  output logic                    w_last_word,
  output logic                    w_last
);

  localparam int NPW = DATA_WIDTH / WEIGHT_WIDTH;
  localparam int IW  = (NPW > 1) ? $clog2(NPW) : 1;
  localparam int CW  = $clog2(NUM_WORDS + 1);

  localparam logic [IW-1:0] IDX_LAST = IW'(NPW - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] WORDS_C = CW'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_C =
    ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] lut_address_q, lut_address_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [CW-1:0]         word_q, word_d;
  logic                  pend1_q, pend1_d;
  logic                  pend2_q, pend2_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;

  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  valid_q, valid_d;

  logic       xfer;
  logic       word_end;
  logic       final_xfer;
  logic       issue;
  logic       can_issue;
  logic       push;
  logic       pop;
  logic [2:0] occ;

  // Handshake qualifiers and read-issue admission.
  always_comb begin
    xfer       = valid_q & w_ready;
    word_end   = xfer && (idx_q == IDX_LAST);
    final_xfer = word_end && (word_q == WORD_LAST);
    occ        = {1'b0, fifo_cnt_q}
               + {2'b00, pend1_q}
               + {2'b00, pend2_q};
    can_issue  = (issued_q < WORDS_C)
               && (occ < 3'd2);
    push       = pend2_q;
    pop        = (fifo_cnt_q != 2'd0)
               && (!valid_q || word_end);
  end

  // Run control: state, address walk, done pulse.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    lut_address_d = lut_address_q;
    issued_d      = issued_q;
    done_d        = 1'b0;
    issue         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          issue         = 1'b1;
          lut_address_d = BASE_ADDR;
          addr_d        = BASE_ADDR + STRIDE_C;
          issued_d      = CW'(1);
          if (NUM_WORDS == 1) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (can_issue) begin
          issue         = 1'b1;
          lut_address_d = addr_q;
          addr_d        = addr_q + STRIDE_C;
          issued_d      = issued_q + CW'(1);
          if (issued_q == WORD_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (final_xfer) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ROM latency pipe and 2-entry word FIFO.
  always_comb begin
    pend1_d    = issue;
    pend2_d    = pend1_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = lut_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Serializer: shift out one weight per handshake.
  always_comb begin
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    word_d  = word_q;
    if (state_q == S_IDLE && start) begin
      word_d = '0;
    end
    if (xfer) begin
      sreg_d = sreg_q << WEIGHT_WIDTH;
      idx_d  = idx_q + IW'(1);
    end
    if (word_end) begin
      valid_d = 1'b0;
      idx_d   = '0;
      word_d  = word_q + CW'(1);
    end
    if (pop) begin
      sreg_d  = mem_q[rd_ptr_q];
      idx_d   = '0;
      valid_d = 1'b1;
    end
  end

  // All state registers, cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      lut_address_q <= '0;
      issued_q      <= '0;
      word_q        <= '0;
      pend1_q       <= 1'b0;
      pend2_q       <= 1'b0;
      done_q        <= 1'b0;
      mem_q[0]      <= '0;
      mem_q[1]      <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      sreg_q        <= '0;
      idx_q         <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      lut_address_q <= lut_address_d;
      issued_q      <= issued_d;
      word_q        <= word_d;
      pend1_q       <= pend1_d;
      pend2_q       <= pend2_d;
      done_q        <= done_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      sreg_q        <= sreg_d;
      idx_q         <= idx_d;
      valid_q       <= valid_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign lut_address = lut_address_q;
  assign w_valid     = valid_q;
  assign w_data      =
    sreg_q[DATA_WIDTH-1 -: WEIGHT_WIDTH];
  assign w_last_word = valid_q && (idx_q == IDX_LAST);
  assign w_last      = w_last_word
                     && (word_q == WORD_LAST);

endmodule
